control_escritura_rtc: RTL and testbench
========================================

CONTROL_ESCRITURA_RTC -- requirements
Module: control_escritura_rtc

Interface
REQ-001 Parameter GAP_CYC, default 2: idle cycles inserted after each acknowledged RTC bus write.
REQ-002 Parameter TIMEOUT_CYC, default 255: cycles to wait for bus_ack before abort (used only with TIMEOUT_EN).
REQ-003 Clock and reset SHALL be: one clock, reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 write_strobe  input  1  PicoBlaze write qualifier.
REQ-007 port_id  input  8  PicoBlaze port address.
REQ-008 out_port  input  8  PicoBlaze write data.
REQ-009 bus_ack  input  1  one-cycle pulse from RTC bus driver: current write finished.
REQ-010 bus_req  output  1  write request to RTC bus driver, held until bus_ack.
REQ-011 bus_addr  output  8  RTC register address of current write.
REQ-012 bus_data  output  8  data of current write.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse on sequence completion.
REQ-015 dirty  output  9  pending-write flags, bit0=seg_hora ... bit8=hora_timer.
REQ-016 error  output  1  sticky timeout flag (constant 0 without TIMEOUT_EN).

Function
REQ-017 Shadow index i (0..8) SHALL map port_id 03,04,05,06,07,08,0A,0B,0C to RTC addresses 21,22,23,24,25,26,41,42,43 (hex): seg/min/hora hora, dia/mes/jahr fecha, seg/min/hora timer.
REQ-018 write_strobe=1 with a mapped port_id SHALL load out_port into shadow[i] and set dirty[i] on the next edge, in any state.
REQ-019 write_strobe=1 with port_id=8'h0F SHALL be the start command; ignored when busy=1.
REQ-020 States: IDLE, SCAN, REQ, GAP, DONE; start in IDLE moves to SCAN with idx=0.
REQ-021 SCAN: if dirty[idx] go REQ; else if idx=8 go DONE; else idx+1, stay SCAN (one index per cycle).
REQ-022 REQ: bus_req=1, bus_addr/bus_data registered from idx/shadow[idx] on REQ entry and stable until bus_ack.
REQ-023 bus_ack in REQ SHALL clear dirty[idx] and move to GAP for GAP_CYC cycles, then SCAN with idx+1, or DONE if idx=8.
REQ-024 A capture to shadow[idx] in the same cycle as bus_ack SHALL leave dirty[idx]=1 (set wins over clear).
REQ-025 A capture to an index already passed in the current sequence SHALL remain dirty for the next start.
REQ-026 bus_ack outside REQ SHALL be ignored.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE.
REQ-028 Start with dirty=0 SHALL produce done 10 cycles after the start edge (9 SCAN + DONE) with no bus_req.

Reset
REQ-029 reset SHALL force IDLE, idx=0, all shadows 8'h00, dirty=0, bus_req=0, bus_addr=0, bus_data=0, busy=0, done=0, error=0.
REQ-030 reset during REQ SHALL drop bus_req on the next edge; the aborted write is not retried.
REQ-031 reset SHALL take priority over capture and start in the same cycle.

Configuration
REQ-032 Macro TIMEOUT_EN defined: a counter runs in REQ; reaching TIMEOUT_CYC without bus_ack sets error, drops bus_req, keeps dirty[idx], goes DONE; error clears only on reset or next accepted start.
REQ-033 TIMEOUT_EN undefined: no counter, REQ waits indefinitely, error tied to 0.

Verification
REQ-034 Write 8'h45 to port 04, start, ack after 3 cycles -> one bus_req with addr 22, data 45; dirty=0; done pulse; busy low after.
REQ-035 Write ports 03,08,0C, start, immediate acks -> writes to 21,26,43 in that order, GAP_CYC idle cycles between, single done.
REQ-036 During REQ for port 05, write 8'h12 to 05 on the ack cycle -> dirty[2]=1 after done; second start resends 23 with 12.
REQ-037 Start with dirty=0 -> done exactly 10 cycles after start, bus_req never asserted.
REQ-038 TIMEOUT_EN, no ack -> bus_req drops after 255 cycles, error=1, dirty bit kept, done pulse.
REQ-039 Assert reset mid-REQ -> next cycle all outputs at reset values, later starts behave normally.

Source files
------------

// File: rtl/control_escritura_rtc_if.sv
`default_nettype none
// ============================================================================
// Module   : control_escritura_rtc_if
// Purpose  : PicoBlaze write port plus RTC bus handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface control_escritura_rtc_if;
   logic       write_strobe;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       bus_ack;
   logic       bus_req;
   logic [7:0] bus_addr;
   logic [7:0] bus_data;
   logic       busy;
   logic       done;
   logic [8:0] dirty;
   logic       error;

   modport slave (
      input  write_strobe, port_id, out_port, bus_ack,
      output bus_req, bus_addr, bus_data, busy, done, dirty, error
   );

   modport master (
      output write_strobe, port_id, out_port, bus_ack,
      input  bus_req, bus_addr, bus_data, busy, done, dirty, error
   );
endinterface
`default_nettype wire

// File: rtl/control_escritura_rtc.sv
`default_nettype none
// ============================================================================
// Module   : control_escritura_rtc
// Purpose  : Shadows PicoBlaze RTC register writes and replays the dirty ones
//            onto the RTC bus on a start command. Macro TIMEOUT_EN adds an
//            ack timeout with a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module control_escritura_rtc #(
   parameter int GAP_CYC     = 2,
   parameter int TIMEOUT_CYC = 255
) (
   input  wire logic               clk,
   input  wire logic               reset,
   control_escritura_rtc_if.slave  bus
);
   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_REQ, S_GAP, S_DONE} state_t;

   localparam int GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

   state_t          r_state, w_state_nx;
   logic [3:0]      r_idx, w_idx_nx;
   logic [7:0]      r_shadow [9];
   logic [8:0]      r_dirty;
   logic [7:0]      r_addr, r_data;
   logic [GW-1:0]   r_gap;
   logic            w_load, w_start, w_ack, w_last, w_tmo;
   logic            w_cap_hit;
   logic [3:0]      w_cap_idx;
   logic [7:0]      w_map_addr;
   logic [8:0]      w_set_mask, w_clr_mask;

   always_comb begin
      w_cap_idx = 4'd0;
      w_cap_hit = bus.write_strobe;
      case (bus.port_id)
         8'h03:   w_cap_idx = 4'd0;
         8'h04:   w_cap_idx = 4'd1;
         8'h05:   w_cap_idx = 4'd2;
         8'h06:   w_cap_idx = 4'd3;
         8'h07:   w_cap_idx = 4'd4;
         8'h08:   w_cap_idx = 4'd5;
         8'h0A:   w_cap_idx = 4'd6;
         8'h0B:   w_cap_idx = 4'd7;
         8'h0C:   w_cap_idx = 4'd8;
         default: w_cap_hit = 1'b0;
      endcase
   end

   always_comb begin
      case (r_idx)
         4'd0:    w_map_addr = 8'h21;
         4'd1:    w_map_addr = 8'h22;
         4'd2:    w_map_addr = 8'h23;
         4'd3:    w_map_addr = 8'h24;
         4'd4:    w_map_addr = 8'h25;
         4'd5:    w_map_addr = 8'h26;
         4'd6:    w_map_addr = 8'h41;
         4'd7:    w_map_addr = 8'h42;
         default: w_map_addr = 8'h43;
      endcase
   end

   assign w_start    = bus.write_strobe && (bus.port_id == 8'h0F) && (r_state == S_IDLE);
   assign w_ack      = (r_state == S_REQ) && bus.bus_ack;
   assign w_last     = (r_idx == 4'd8);
   assign w_set_mask = w_cap_hit ? (9'd1 << w_cap_idx) : 9'd0;
   assign w_clr_mask = w_ack ? (9'd1 << r_idx) : 9'd0;

`ifdef TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   logic [TW-1:0] r_tmo;
   logic          r_error;

   assign w_tmo     = (r_state == S_REQ) && !bus.bus_ack && (r_tmo == TW'(TIMEOUT_CYC - 1));
   assign bus.error = r_error;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tmo   <= '0;
         r_error <= 1'b0;
      end else begin
         r_tmo <= (r_state == S_REQ) ? r_tmo + 1'b1 : '0;
         if (w_start)
            r_error <= 1'b0;
         else if (w_tmo)
            r_error <= 1'b1;
      end
   end
`else
   assign w_tmo     = 1'b0;
   assign bus.error = 1'b0;
`endif

   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_load     = 1'b0;
      case (r_state)
         S_IDLE: if (w_start) begin
            w_state_nx = S_SCAN;
            w_idx_nx   = 4'd0;
         end
         S_SCAN: if (r_dirty[r_idx]) begin
            w_state_nx = S_REQ;
            w_load     = 1'b1;
         end else if (w_last) begin
            w_state_nx = S_DONE;
         end else begin
            w_idx_nx = r_idx + 4'd1;
         end
         S_REQ: if (bus.bus_ack) begin
            if (GAP_CYC > 0) begin
               w_state_nx = S_GAP;
            end else begin
               w_state_nx = w_last ? S_DONE : S_SCAN;
               w_idx_nx   = w_last ? r_idx : r_idx + 4'd1;
            end
         end else if (w_tmo) begin
            w_state_nx = S_DONE;
         end
         S_GAP: if (r_gap == GW'(GAP_LAST)) begin
            w_state_nx = w_last ? S_DONE : S_SCAN;
            w_idx_nx   = w_last ? r_idx : r_idx + 4'd1;
         end
         S_DONE:  w_state_nx = S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // A capture in the ack cycle re-sets the bit that the ack clears.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_idx   <= 4'd0;
         r_dirty <= 9'd0;
         r_addr  <= 8'h00;
         r_data  <= 8'h00;
         r_gap   <= '0;
         for (int i = 0; i < 9; i++)
            r_shadow[i] <= 8'h00;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_dirty <= (r_dirty & ~w_clr_mask) | w_set_mask;
         r_gap   <= (r_state == S_GAP) ? r_gap + 1'b1 : '0;
         if (w_load) begin
            r_addr <= w_map_addr;
            r_data <= r_shadow[r_idx];
         end
         if (w_cap_hit)
            r_shadow[w_cap_idx] <= bus.out_port;
      end
   end

   assign bus.bus_req  = (r_state == S_REQ);
   assign bus.bus_addr = r_addr;
   assign bus.bus_data = r_data;
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = (r_state == S_DONE);
   assign bus.dirty    = r_dirty;
endmodule
`default_nettype wire

// File: tb/tb_control_escritura_rtc.sv
`default_nettype none
// Bench for control_escritura_rtc: transaction-level reference model with a
// per-cycle compare, directed scenarios and a randomized soak.
module tb_control_escritura_rtc;
   localparam int GAP = 2;
   localparam int TMO = 255;

   logic clk = 1'b0;
   logic reset = 1'b1;
   control_escritura_rtc_if bif();

   control_escritura_rtc #(.GAP_CYC(GAP), .TIMEOUT_CYC(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   initial forever #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // ---------------- ack generation ----------------
   int   ack_mode  = 0;
   int   ack_fixed = -1;
   bit   spur_on   = 1'b0;
   logic man_ack   = 1'b0;
   logic auto_ack  = 1'b0;
   assign bif.bus_ack = (ack_mode == 1) ? auto_ack : man_ack;

   initial begin
      int ack_wait;
      ack_wait = -1;
      forever begin
         @(negedge clk);
         auto_ack = 1'b0;
         if (ack_mode == 1 && bif.bus_req) begin
            if (ack_wait < 0)
               ack_wait = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 4));
            if (ack_wait == 0) begin
               auto_ack = 1'b1;
               ack_wait = -1;
            end else begin
               ack_wait--;
            end
         end else begin
            ack_wait = -1;
            if (spur_on && $urandom_range(0, 7) == 0)
               auto_ack = 1'b1;
         end
      end
   end

   // ---------------- reference model ----------------
   logic [7:0] m_shadow [9];
   logic [8:0] m_dirty;
   logic       m_error;
   logic       exp_busy, exp_req, exp_done;
   logic [7:0] exp_addr, exp_data;
   logic       s_rst, s_we, s_ack;
   logic [7:0] s_pid, s_dat;

   function automatic int port_idx(input logic [7:0] p);
      if (p >= 8'h03 && p <= 8'h08) return int'(p) - 3;
      if (p >= 8'h0A && p <= 8'h0C) return int'(p) - 4;
      return -1;
   endfunction

   function automatic logic [7:0] rtc_addr(input int i);
      return (i < 6) ? 8'h21 + 8'(i) : 8'h41 + 8'(i - 6);
   endfunction

   task automatic m_edge();
      @(posedge clk);
      s_rst = reset;
      s_we  = bif.write_strobe;
      s_pid = bif.port_id;
      s_dat = bif.out_port;
      s_ack = bif.bus_ack;
   endtask

   task automatic m_reset();
      for (int i = 0; i < 9; i++) m_shadow[i] = 8'h00;
      m_dirty  = 9'd0;
      m_error  = 1'b0;
      exp_busy = 1'b0;
      exp_req  = 1'b0;
      exp_done = 1'b0;
      exp_addr = 8'h00;
      exp_data = 8'h00;
   endtask

   task automatic m_commit(input int clr);
      int k;
      if (clr >= 0) m_dirty[clr] = 1'b0;
      k = s_we ? port_idx(s_pid) : -1;
      if (k >= 0) begin
         m_shadow[k] = s_dat;
         m_dirty[k]  = 1'b1;
      end
   endtask

   task automatic m_sequence();
      bit         tmo;
      bit         d;
      int         cnt;
      logic [7:0] dat;
      tmo = 1'b0;
      for (int i = 0; i < 9; i++) begin
         exp_busy = 1'b1; exp_req = 1'b0; exp_done = 1'b0;
         d   = m_dirty[i];
         dat = m_shadow[i];
         m_edge();
         if (s_rst) begin m_reset(); return; end
         m_commit(-1);
         if (!d) continue;
         exp_req  = 1'b1;
         exp_addr = rtc_addr(i);
         exp_data = dat;
         cnt = 0;
         forever begin
            m_edge();
            if (s_rst) begin m_reset(); return; end
            if (s_ack) begin m_commit(i); break; end
            m_commit(-1);
            cnt++;
`ifdef TIMEOUT_EN
            if (cnt == TMO) begin m_error = 1'b1; tmo = 1'b1; break; end
`endif
         end
         exp_req = 1'b0;
         if (tmo) break;
         for (int g = 0; g < GAP; g++) begin
            m_edge();
            if (s_rst) begin m_reset(); return; end
            m_commit(-1);
         end
      end
      exp_busy = 1'b1; exp_req = 1'b0; exp_done = 1'b1;
      m_edge();
      if (s_rst) begin m_reset(); return; end
      m_commit(-1);
      exp_busy = 1'b0; exp_done = 1'b0;
   endtask

   initial begin
      m_reset();
      forever begin
         m_edge();
         if (s_rst) begin
            m_reset();
         end else if (s_we && s_pid == 8'h0F) begin
            m_commit(-1);
            m_error = 1'b0;
            m_sequence();
         end else begin
            m_commit(-1);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         total++;
         if (bif.busy !== exp_busy || bif.bus_req !== exp_req || bif.done !== exp_done ||
             bif.bus_addr !== exp_addr || bif.bus_data !== exp_data ||
             bif.dirty !== m_dirty || bif.error !== m_error) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t: got busy=%b req=%b done=%b addr=%h data=%h dirty=%b err=%b, want busy=%b req=%b done=%b addr=%h data=%h dirty=%b err=%b",
                     $time, bif.busy, bif.bus_req, bif.done, bif.bus_addr, bif.bus_data, bif.dirty, bif.error,
                     exp_busy, exp_req, exp_done, exp_addr, exp_data, m_dirty, m_error);
         end
      end
   end

   // ---------------- transaction monitor ----------------
   logic [7:0] addr_q [$];
   int         done_cnt = 0;
   initial begin
      logic prev_req;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (bif.bus_req === 1'b1 && !prev_req) addr_q.push_back(bif.bus_addr);
         if (bif.done === 1'b1) done_cnt++;
         prev_req = (bif.bus_req === 1'b1);
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic wr(input logic [7:0] p, input logic [7:0] d);
      @(negedge clk);
      bif.write_strobe = 1'b1;
      bif.port_id      = p;
      bif.out_port     = d;
      @(negedge clk);
      bif.write_strobe = 1'b0;
   endtask

   task automatic wait_req(input string nm);
      int n;
      n = 0;
      while (bif.bus_req !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk({nm, "_req_seen"}, 32'(bif.bus_req === 1'b1), 32'd1);
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (bif.done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
      chk({nm, "_done_seen"}, 32'(bif.done === 1'b1), 32'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] ports [12];
      int n;
      bit req_seen;
      ports = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A, 8'h0B, 8'h0C, 8'h0F, 8'h0F, 8'h09};
      bif.write_strobe = 1'b0;
      bif.port_id      = 8'h00;
      bif.out_port     = 8'h00;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset  = 1'b0;
      chk_en = 1'b1;
      chk("rst_busy",  32'(bif.busy),     32'd0);
      chk("rst_req",   32'(bif.bus_req),  32'd0);
      chk("rst_dirty", 32'(bif.dirty),    32'd0);
      chk("rst_addr",  32'(bif.bus_addr), 32'd0);
      chk("rst_error", 32'(bif.error),    32'd0);

      // single write, ack after 3 cycles
      wr(8'h04, 8'h45);
      chk("cap_dirty", 32'(bif.dirty), 32'h002);
      wr(8'h0F, 8'h00);
      wait_req("t1");
      chk("t1_addr", 32'(bif.bus_addr), 32'h22);
      chk("t1_data", 32'(bif.bus_data), 32'h45);
      repeat (3) @(negedge clk);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      wait_done("t1");
      chk("t1_dirty", 32'(bif.dirty), 32'd0);
      @(negedge clk);
      chk("t1_busy_after", 32'(bif.busy), 32'd0);

      // empty start: done in the 10th cycle, no request
      @(negedge clk);
      bif.write_strobe = 1'b1;
      bif.port_id      = 8'h0F;
      n = 0;
      req_seen = 1'b0;
      while (n < 50) begin
         @(negedge clk);
         bif.write_strobe = 1'b0;
         n++;
         if (bif.bus_req === 1'b1) req_seen = 1'b1;
         if (bif.done === 1'b1) break;
      end
      chk("t2_done_latency", 32'(n), 32'd10);
      chk("t2_no_req", 32'(req_seen), 32'd0);
      @(negedge clk);

      // three writes, immediate acks, ordered replay
      ack_mode = 1; ack_fixed = 0;
      wr(8'h0C, 8'hC1);
      wr(8'h03, 8'h31);
      wr(8'h08, 8'h81);
      addr_q.delete();
      done_cnt = 0;
      wr(8'h0F, 8'h00);
      wait_done("t3");
      @(negedge clk);
      chk("t3_nreq", 32'(addr_q.size()), 32'd3);
      if (addr_q.size() == 3) begin
         chk("t3_a0", 32'(addr_q[0]), 32'h21);
         chk("t3_a1", 32'(addr_q[1]), 32'h26);
         chk("t3_a2", 32'(addr_q[2]), 32'h43);
      end
      chk("t3_done_cnt", 32'(done_cnt), 32'd1);

      // capture on the ack cycle keeps the bit dirty
      ack_mode = 0;
      wr(8'h05, 8'hAA);
      wr(8'h0F, 8'h00);
      wait_req("t4");
      chk("t4_addr", 32'(bif.bus_addr), 32'h23);
      @(negedge clk);
      man_ack = 1'b1;
      bif.write_strobe = 1'b1; bif.port_id = 8'h05; bif.out_port = 8'h12;
      @(negedge clk);
      man_ack = 1'b0;
      bif.write_strobe = 1'b0;
      wait_done("t4");
      chk("t4_dirty_kept", 32'(bif.dirty), 32'h004);
      @(negedge clk);
      wr(8'h0F, 8'h00);
      wait_req("t4b");
      chk("t4b_addr", 32'(bif.bus_addr), 32'h23);
      chk("t4b_data", 32'(bif.bus_data), 32'h12);
      man_ack = 1'b1;
      @(negedge clk);
      man_ack = 1'b0;
      wait_done("t4b");
      chk("t4b_dirty", 32'(bif.dirty), 32'd0);

      // reset in the middle of a request
      wr(8'h06, 8'h77);
      wr(8'h0F, 8'h00);
      wait_req("t5");
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("t5_req",   32'(bif.bus_req),  32'd0);
      chk("t5_busy",  32'(bif.busy),     32'd0);
      chk("t5_dirty", 32'(bif.dirty),    32'd0);
      chk("t5_data",  32'(bif.bus_data), 32'd0);
      ack_mode = 1; ack_fixed = -1;
      wr(8'h0B, 8'h5A);
      wr(8'h0F, 8'h00);
      wait_done("t5b");
      chk("t5b_dirty", 32'(bif.dirty), 32'd0);

`ifdef TIMEOUT_EN
      // no ack: request held for TMO cycles then abandoned
      ack_mode = 0;
      wr(8'h07, 8'h33);
      wr(8'h0F, 8'h00);
      wait_req("t6");
      n = 0;
      while (bif.bus_req === 1'b1 && n < 400) begin @(negedge clk); n++; end
      chk("t6_req_cycles", 32'(n), 32'(TMO));
      chk("t6_error", 32'(bif.error), 32'd1);
      chk("t6_done",  32'(bif.done),  32'd1);
      chk("t6_dirty", 32'(bif.dirty), 32'h010);
      ack_mode = 1;
      @(negedge clk);
      wr(8'h0F, 8'h00);
      chk("t6_err_clr", 32'(bif.error), 32'd0);
      wait_done("t6b");
`endif

      // randomized soak
      ack_mode = 1; ack_fixed = -1; spur_on = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         int r;
         @(negedge clk);
         r = int'($urandom_range(0, 199));
         reset            = (r == 0);
         bif.write_strobe = (r >= 1 && r < 60);
         bif.port_id      = ports[$urandom_range(0, 11)];
         if ($urandom_range(0, 15) == 0) bif.port_id = 8'($urandom);
         bif.out_port     = 8'($urandom);
      end
      @(negedge clk);
      reset = 1'b0;
      bif.write_strobe = 1'b0;
      spur_on = 1'b0;
      repeat (80) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
